// File: rtl/feed_arbiter.sv
// feed_arbiter: packet-granular round-robin merge of NUM_PORTS AXI-stream feeds onto the shared filter input.
// Grant is held from the first beat through the accepted tlast beat; per-port packet counters saturate.
module feed_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 32,
   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_PORTS-1:0]              port_enable,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   slave_tdata,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] slave_byteEnable,
   input  logic [NUM_PORTS-1:0]              slave_tvalid,
   input  logic [NUM_PORTS-1:0]              slave_tlast,
   output logic [NUM_PORTS-1:0]              slave_tready,
   output logic [DATA_WIDTH-1:0]             master_tdata,
   output logic [DATA_WIDTH/8-1:0]           master_byteEnable,
   output logic                              master_tvalid,
   output logic                              master_tlast,
   input  logic                              master_tready,
   output logic [GW-1:0]                     grant_id,
   output logic                              busy,
   output logic [NUM_PORTS*CNT_WIDTH-1:0]    pkt_count
);
   localparam int BW = DATA_WIDTH/8;
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t               r_state, w_next;
   logic [GW-1:0]        r_grant, r_last, w_pick;
   logic [CNT_WIDTH-1:0] r_cnt [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_req;
   logic                 w_done;
   int                   w_best;

   assign w_req    = slave_tvalid & port_enable;
   assign w_done   = master_tvalid & master_tready & master_tlast;
   assign grant_id = r_grant;
   assign busy     = r_state == LOCKED;

   // distance 0 is the port just after last_grant; the nearest requester wins
   always_comb begin
      w_pick = '0;
      w_best = NUM_PORTS;
      for (int i = 0; i < NUM_PORTS; i++)
         if (w_req[i] && (i + NUM_PORTS - 1 - int'(r_last)) % NUM_PORTS < w_best) begin
            w_best = (i + NUM_PORTS - 1 - int'(r_last)) % NUM_PORTS;
            w_pick = GW'(i);
         end
   end

   always_comb begin
      master_tdata      = '0;
      master_byteEnable = '0;
      master_tvalid     = 1'b0;
      master_tlast      = 1'b0;
      slave_tready      = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         if (busy && r_grant == GW'(i)) begin
            master_tdata      = slave_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            master_byteEnable = slave_byteEnable[i*BW +: BW];
            master_tvalid     = slave_tvalid[i];
            master_tlast      = slave_tlast[i];
            slave_tready[i]   = master_tready;
         end
   end

   always_comb w_next = (r_state == IDLE) ? ((|w_req) ? LOCKED : IDLE) : (w_done ? IDLE : LOCKED);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_last  <= GW'(NUM_PORTS - 1);
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && |w_req) r_grant <= w_pick;
         if (w_done) r_last <= r_grant;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_cnt <= '{default: '0};
      else
         for (int i = 0; i < NUM_PORTS; i++)
            if (w_done && r_grant == GW'(i) && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
      assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
   end
endmodule

// File: tb/tb_feed_arbiter.sv
// tb_feed_arbiter: directed and randomized checks of feed_arbiter against a packet-level reference model.
module tb_feed_arbiter;
   localparam int NP = 4, DW = 64, CW = 4, BW = DW/8, GW = 2;

   logic clk = 1'b0, rst = 1'b0;
   logic [NP-1:0]    port_enable, slave_tvalid, slave_tlast, slave_tready;
   logic [NP*DW-1:0] slave_tdata;
   logic [NP*BW-1:0] slave_byteEnable;
   logic [DW-1:0]    master_tdata;
   logic [BW-1:0]    master_byteEnable;
   logic             master_tvalid, master_tlast, master_tready;
   logic [GW-1:0]    grant_id;
   logic             busy;
   logic [NP*CW-1:0] pkt_count;

   int n_chk = 0, n_err = 0, cyc = 0;
   int log_g[$], log_c[$];
   logic [DW-1:0] acc_q[$];
   logic m_busy;
   int m_grant, m_last;
   int m_cnt [NP];

   feed_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .port_enable(port_enable),
      .slave_tdata(slave_tdata), .slave_byteEnable(slave_byteEnable),
      .slave_tvalid(slave_tvalid), .slave_tlast(slave_tlast), .slave_tready(slave_tready),
      .master_tdata(master_tdata), .master_byteEnable(master_byteEnable),
      .master_tvalid(master_tvalid), .master_tlast(master_tlast), .master_tready(master_tready),
      .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // reference: one packet at a time per grant, rotating search from the last finished port
   always @(negedge clk) begin
      logic [NP-1:0] req, e_rdy;
      logic [DW-1:0] e_data;
      logic [BW-1:0] e_be;
      logic [NP*CW-1:0] e_cnt;
      logic e_v, e_l;
      if (!rst) begin
         m_busy = 1'b0;
         m_grant = 0;
         m_last = NP - 1;
         foreach (m_cnt[i]) m_cnt[i] = 0;
      end
      e_v = 1'b0; e_l = 1'b0; e_data = '0; e_be = '0; e_rdy = '0;
      if (m_busy) begin
         e_v = slave_tvalid[m_grant];
         e_l = slave_tlast[m_grant];
         e_data = slave_tdata[m_grant*DW +: DW];
         e_be = slave_byteEnable[m_grant*BW +: BW];
         e_rdy[m_grant] = master_tready;
      end
      foreach (m_cnt[i]) e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
      chk("busy", 64'(busy), 64'(m_busy));
      chk("grant_id", 64'(grant_id), 64'(m_grant));
      chk("master_tvalid", 64'(master_tvalid), 64'(e_v));
      chk("master_tlast", 64'(master_tlast), 64'(e_l));
      chk("master_tdata", master_tdata, e_data);
      chk("master_byteEnable", 64'(master_byteEnable), 64'(e_be));
      chk("slave_tready", 64'(slave_tready), 64'(e_rdy));
      chk("pkt_count", 64'(pkt_count), 64'(e_cnt));
      if (rst) begin
         if (master_tvalid && master_tready) acc_q.push_back(master_tdata);
         if (busy && master_tvalid && master_tready && master_tlast) begin
            log_g.push_back(int'(grant_id));
            log_c.push_back(cyc);
         end
         if (!m_busy) begin
            req = slave_tvalid & port_enable;
            for (int k = 1; k <= NP; k++)
               if (req[(m_last + k) % NP]) begin
                  m_grant = (m_last + k) % NP;
                  m_busy = 1'b1;
                  break;
               end
         end else if (slave_tvalid[m_grant] && master_tready && slave_tlast[m_grant]) begin
            m_busy = 1'b0;
            m_last = m_grant;
            if (m_cnt[m_grant] < 2**CW - 1) m_cnt[m_grant]++;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic v, input logic [DW-1:0] d, input logic l);
      slave_tvalid[p] = v;
      slave_tlast[p] = l;
      slave_tdata[p*DW +: DW] = d;
      slave_byteEnable[p*BW +: BW] = v ? 8'hFF : 8'h00;
   endtask

   task automatic do_reset;
      slave_tvalid = '0;
      slave_tlast = '0;
      slave_tdata = '0;
      slave_byteEnable = '0;
      port_enable = '1;
      master_tready = 1'b1;
      rst = 1'b0;
      repeat (2) tick;
      log_g.delete();
      log_c.delete();
      acc_q.delete();
      rst = 1'b1;
   endtask

   task automatic run_gen(input int n_pkts, input int max_cyc, input int vprob, input int rprob,
                          input int lmin, input int lmax, input logic rand_en);
      int len [NP];
      int beat [NP];
      int c;
      logic [NP-1:0] acc;
      c = 0;
      for (int i = 0; i < NP; i++) begin
         beat[i] = 0;
         len[i] = $urandom_range(lmax, lmin);
         slave_tdata[i*DW +: DW] = {$urandom, $urandom};
         slave_byteEnable[i*BW +: BW] = 8'($urandom);
      end
      while (log_g.size() < n_pkts && c < max_cyc) begin
         for (int i = 0; i < NP; i++) begin
            slave_tvalid[i] = $urandom_range(99, 0) < vprob;
            slave_tlast[i] = beat[i] == len[i] - 1;
         end
         master_tready = $urandom_range(99, 0) < rprob;
         if (rand_en && $urandom_range(9, 0) == 0) port_enable = NP'($urandom);
         @(negedge clk);
         acc = slave_tvalid & slave_tready;
         tick;
         c++;
         for (int i = 0; i < NP; i++)
            if (acc[i]) begin
               if (beat[i] == len[i] - 1) begin
                  beat[i] = 0;
                  len[i] = $urandom_range(lmax, lmin);
               end else beat[i]++;
               slave_tdata[i*DW +: DW] = {$urandom, $urandom};
               slave_byteEnable[i*BW +: BW] = 8'($urandom);
            end
      end
      chk("gen_pkts_done", 64'(log_g.size() >= n_pkts), 64'd1);
      slave_tvalid = '0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      port_enable = '1;
      slave_tvalid = '0;
      slave_tlast = '0;
      slave_tdata = '0;
      slave_byteEnable = '0;
      master_tready = 1'b1;
      repeat (3) tick;
      rst = 1'b1;
      // reset and idle
      repeat (10) tick;
      chk("t1_busy", 64'(busy), 64'd0);
      chk("t1_grant", 64'(grant_id), 64'd0);
      chk("t1_tready", 64'(slave_tready), 64'd0);
      chk("t1_count", 64'(pkt_count), 64'd0);
      // single feed, 3-beat packet on port 2
      do_reset;
      set_port(2, 1'b1, 64'h00474F4F47000000, 1'b0);
      tick;
      chk("t2_grant", 64'(grant_id), 64'd2);
      chk("t2_busy", 64'(busy), 64'd1);
      chk("t2_word0", master_tdata, 64'h00474F4F47000000);
      tick;
      set_port(2, 1'b1, 64'h12345678, 1'b0);
      #1 chk("t2_word1", master_tdata, 64'h12345678);
      tick;
      set_port(2, 1'b1, 64'h876654321, 1'b1);
      #1 chk("t2_word2", master_tdata, 64'h876654321);
      chk("t2_last", 64'(master_tlast), 64'd1);
      tick;
      set_port(2, 1'b0, 64'h0, 1'b0);
      #1 chk("t2_idle", 64'(busy), 64'd0);
      chk("t2_count", 64'(pkt_count[2*CW +: CW]), 64'd1);
      // round-robin fairness with 2-beat packets
      do_reset;
      run_gen(8, 200, 100, 100, 2, 2, 1'b0);
      for (int k = 0; k < 8; k++) chk("t3_order", 64'(log_g[k]), 64'(k % 4));
      for (int k = 1; k < 8; k++) chk("t3_gap", 64'(log_c[k] - log_c[k-1]), 64'd3);
      chk("t3_counts", 64'(pkt_count), 64'h2222);
      // backpressure: port 1 stalls while port 0 waits
      do_reset;
      set_port(0, 1'b1, 64'hA0, 1'b1);
      repeat (2) tick;
      set_port(0, 1'b1, 64'hC0, 1'b1);
      set_port(1, 1'b1, 64'hB0, 1'b0);
      tick;
      chk("t4_grant1", 64'(grant_id), 64'd1);
      tick;
      set_port(1, 1'b1, 64'hB1, 1'b0);
      master_tready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1 chk("t4_stall_grant", 64'(grant_id), 64'd1);
         chk("t4_stall_tready", 64'(slave_tready), 64'd0);
         chk("t4_stall_data", master_tdata, 64'hB1);
         tick;
      end
      master_tready = 1'b1;
      tick;
      set_port(1, 1'b1, 64'hB2, 1'b1);
      tick;
      set_port(1, 1'b0, 64'h0, 1'b0);
      #1 chk("t4_idle", 64'(busy), 64'd0);
      tick;
      chk("t4_grant0", 64'(grant_id), 64'd0);
      tick;
      set_port(0, 1'b0, 64'h0, 1'b0);
      chk("t4_beats", 64'(acc_q.size()), 64'd5);
      chk("t4_beat0", acc_q[0], 64'hA0);
      chk("t4_beat1", acc_q[1], 64'hB0);
      chk("t4_beat2", acc_q[2], 64'hB1);
      chk("t4_beat3", acc_q[3], 64'hB2);
      chk("t4_beat4", acc_q[4], 64'hC0);
      // enable mask: only odd ports may win
      do_reset;
      port_enable = 4'b1010;
      run_gen(10, 400, 100, 60, 1, 3, 1'b0);
      foreach (log_g[k]) chk("t5_mask_odd", 64'(log_g[k] % 2), 64'd1);
      do_reset;
      port_enable = 4'b1010;
      set_port(1, 1'b1, 64'hD0, 1'b0);
      tick;
      chk("t5_grant1", 64'(grant_id), 64'd1);
      tick;
      port_enable = 4'b1000;
      set_port(1, 1'b1, 64'hD1, 1'b0);
      tick;
      set_port(1, 1'b1, 64'hD2, 1'b1);
      tick;
      set_port(1, 1'b0, 64'h0, 1'b0);
      #1 chk("t5_count1", 64'(pkt_count[1*CW +: CW]), 64'd1);
      // reset mid-packet on port 3
      do_reset;
      set_port(3, 1'b1, 64'hE0, 1'b0);
      tick;
      chk("t6_grant3", 64'(grant_id), 64'd3);
      tick;
      set_port(3, 1'b1, 64'hE1, 1'b0);
      #1 rst = 1'b0;
      #1 chk("t6_tvalid", 64'(master_tvalid), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_tready", 64'(slave_tready), 64'd0);
      chk("t6_tdata", master_tdata, 64'd0);
      chk("t6_count3", 64'(pkt_count[3*CW +: CW]), 64'd0);
      tick;
      set_port(1, 1'b1, 64'hF0, 1'b1);
      rst = 1'b1;
      tick;
      chk("t6_regrant", 64'(grant_id), 64'd1);
      // randomized traffic, masks and backpressure; counters saturate
      do_reset;
      run_gen(200, 5000, 70, 70, 1, 4, 1'b1);
      repeat (3) tick;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/feed_arbiter.md
# feed_arbiter

Packet-granular round-robin arbiter that shares the single cut-through ticker filter between NUM_PORTS AXI-stream market-data feeds. Sits directly upstream of the filter: each feed's slave stream enters here, and one merged master stream drives the filter's slave port. A grant is held from the first accepted beat to the accepted tlast beat, so packets are never interleaved. Per-port accepted-packet counters are exposed for host monitoring.

## Interface
- NUM_PORTS, 4, number of ingress feeds (2..8)
- DATA_WIDTH, 64, tdata width; byte-enable width is DATA_WIDTH/8
- CNT_WIDTH, 32, width of each per-port packet counter
- GW (derived), max(1, clog2(NUM_PORTS)), grant index width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- port_enable  in  NUM_PORTS  per-port arbitration enable; bit i=0 excludes port i from new grants
- slave_tdata  in  NUM_PORTS*DATA_WIDTH  port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- slave_byteEnable  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables
- slave_tvalid  in  NUM_PORTS  per-port valid
- slave_tlast  in  NUM_PORTS  per-port end of packet
- slave_tready  out  NUM_PORTS  per-port ready
- master_tdata  out  DATA_WIDTH  to filter
- master_byteEnable  out  DATA_WIDTH/8  to filter
- master_tvalid  out  1  to filter
- master_tlast  out  1  to filter
- master_tready  in  1  from filter
- grant_id  out  GW  index of currently granted port
- busy  out  1  1 while a grant is held (state LOCKED)
- pkt_count  out  NUM_PORTS*CNT_WIDTH  accepted-packet count per port

## Operation
- States: IDLE, LOCKED.
- IDLE: request vector req = slave_tvalid & port_enable. If req is non-zero, pick the first set bit searching upward (with wrap) from last_grant+1, register it into grant_id, and go to LOCKED. If req is zero, stay in IDLE.
- LOCKED: master_* = slave_* of port grant_id (combinational mux). slave_tready[grant_id] = master_tready, all other slave_tready = 0. A beat is accepted when master_tvalid & master_tready. On an accepted beat with master_tlast=1: last_grant <= grant_id, pkt_count[grant_id] increments, and the next state is IDLE.
- In IDLE: master_tvalid=0, master_tlast=0, master_tdata=0, master_byteEnable=0, and all slave_tready=0.
- Deasserting port_enable[grant_id] mid-packet does not abort the packet; the mask gates new grants only.
- A granted port that drops tvalid mid-packet keeps the grant. No timeout.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- last_grant resets to NUM_PORTS-1, so port 0 has priority for the first grant after reset.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, grant_id=0, busy=0, last_grant=NUM_PORTS-1, all pkt_count=0. All master outputs and slave_tready are 0 immediately.
- Reset asserted mid-packet drops the packet in flight; it is not counted. After release, arbitration restarts from port 0.
- Arbitration latency: request seen in IDLE at edge N; grant effective (busy=1, first beat presentable) from edge N+1.
- Data path from granted slave to master has zero register latency. tvalid, tlast, tdata and byteEnable pass through combinationally, and so does master_tready to slave_tready.
- One mandatory IDLE cycle follows every tlast. Maximum throughput is L/(L+1) beats per cycle for L-beat packets.
- A single-beat packet (tlast on the first beat) gives LOCKED for 1 cycle, then IDLE. It is counted once.
- pkt_count updates on the edge that accepts tlast and is visible the following cycle.

## Test plan
- Reset and idle: hold rst=0, then release with all tvalid=0. Required: busy=0, grant_id=0, master_tvalid=0, slave_tready=0000, all pkt_count=0 over 10 cycles.
- Single feed, 3-beat packet: port 2 sends 0x00474F4F47000000, 0x12345678, 0x876654321 (tlast on beat 3), with master_tready=1. Required: grant_id=2 one cycle after tvalid, the three words appear on master_tdata in order, master_tlast on word 3, then busy=0 and pkt_count[2]=1.
- Round-robin fairness: all four ports continuously send 2-beat packets. Required: grant order 0,1,2,3,0,1 with one idle cycle between packets, and each pkt_count=2 after 8 packets.
- Backpressure and lock: master_tready=0 for 5 cycles mid-packet on port 1 while port 0 is requesting. Required: grant stays 1, slave_tready=0000 during the stall, no beat is lost or duplicated, and port 0 is granted only after port 1's tlast.
- Enable mask: port_enable=4'b1010 with all ports valid. Required: only ports 1 and 3 are ever granted. Clearing bit 1 mid-packet on port 1 still completes that packet.
- Reset mid-packet: assert rst=0 on beat 2 of 4 on port 3. Required: outputs go to 0 asynchronously, pkt_count[3]=0, and the next grant after release goes to the lowest requesting port.
